// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: multi-cycle binary-to-BCD converter (double dabble, one bit per clock)
// with start/busy/done handshake, saturating overflow and optional all-ones blank code.
module bin2bcd_seq #(
    parameter int BIN_W         = 12,
    parameter int DIGITS        = 4,
    parameter bit BLANK_ON_ONES = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_n;
    logic [BIN_W-1:0] sr;
    logic [BW-1:0]    scr, adj, scr_sh;
    logic [CW-1:0]    cnt;
    logic             ovf, ovf_sh, blank, last;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        adj = '0;
        for (int k = 0; k < DIGITS; k++)
            adj[4*k +: 4] = scr[4*k +: 4] >= 4'd5 ? scr[4*k +: 4] + 4'd3 : scr[4*k +: 4];
        scr_sh  = {adj[BW-2:0], sr[BIN_W-1]};
        ovf_sh  = ovf | adj[BW-1];
        last    = cnt == CW'(1);
        state_n = state == IDLE ? (start ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
    end

    assign busy = state == SHIFT;

    // A bit leaving the top digit means the value needs more than DIGITS digits.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sr       <= '0;
            scr      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            blank    <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    sr    <= bin_in;
                    scr   <= '0;
                    ovf   <= 1'b0;
                    cnt   <= CW'(BIN_W);
                    blank <= BLANK_ON_ONES && (&bin_in);
                end
            end else begin
                sr  <= sr << 1;
                scr <= scr_sh;
                ovf <= ovf_sh;
                cnt <= cnt - 1'b1;
                if (last) begin
                    done     <= 1'b1;
                    bcd_out  <= blank ? '1 : ovf_sh ? {DIGITS{4'h9}} : scr_sh;
                    overflow <= !blank && ovf_sh;
                end
            end
        end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed scoreboard bench for bin2bcd_seq in three parameterisations
// (defaults, blank disabled, 16-bit input with blank disabled).
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  st = '0;
    logic [11:0] bin_a = '0, bin_b = '0;
    logic [15:0] bin_c = '0;
    logic [2:0]  busy, done, ovf;
    logic [15:0] bcd [3];

    int checks = 0, errors = 0;
    int dcnt [3] = '{0, 0, 0};
    int exp_d [3] = '{0, 0, 0};
    logic [16:0] sb [$];

    always #5 clk = ~clk;

    bin2bcd_seq u_a (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .bin_in(bin_a),
        .busy(busy[0]), .done(done[0]), .bcd_out(bcd[0]), .overflow(ovf[0]));

    bin2bcd_seq #(.BLANK_ON_ONES(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .bin_in(bin_b),
        .busy(busy[1]), .done(done[1]), .bcd_out(bcd[1]), .overflow(ovf[1]));

    bin2bcd_seq #(.BIN_W(16), .BLANK_ON_ONES(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .bin_in(bin_c),
        .busy(busy[2]), .done(done[2]), .bcd_out(bcd[2]), .overflow(ovf[2]));

    always @(negedge clk)
        for (int d = 0; d < 3; d++)
            if (done[d]) dcnt[d]++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_on(input int d, input logic [15:0] v);
        st[d] = 1'b1;
        if (d == 0)      bin_a = v[11:0];
        else if (d == 1) bin_b = v[11:0];
        else             bin_c = v;
    endtask

    task automatic wait_done(input int d, input string tag, input int lat);
        int n = 0;
        int bc = 1;
        logic [16:0] e;
        check({tag, " busy"}, 32'(busy[d]), 32'd1);
        while (!done[d] && n < 100) begin
            tick;
            n++;
            if (busy[d]) bc++;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " busy cycles"}, bc, lat);
        check({tag, " busy at done"}, 32'(busy[d]), 32'd0);
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty at done", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " bcd"}, 32'(bcd[d]), 32'(e[15:0]));
            check({tag, " ovf"}, 32'(ovf[d]), 32'(e[16]));
        end
    endtask

    task automatic conv(input int d, input string tag, input logic [15:0] v,
                        input logic [16:0] e, input int lat);
        start_on(d, v);
        sb.push_back(e);
        exp_d[d]++;
        tick;
        st[d] = 1'b0;
        wait_done(d, tag, lat);
    endtask

    initial begin
        tick;
        tick;
        for (int d = 0; d < 3; d++) begin
            check("reset bcd", 32'(bcd[d]), 32'd0);
            check("reset busy", 32'(busy[d]), 32'd0);
            check("reset done", 32'(done[d]), 32'd0);
            check("reset ovf", 32'(ovf[d]), 32'd0);
        end
        rst_n = 1'b1;
        tick;

        conv(0, "zero", 16'd0, {1'b0, 16'h0000}, 12);
        conv(0, "4094", 16'd4094, {1'b0, 16'h4094}, 12);

        // result must hold while the next conversion runs
        start_on(0, 16'h0FFF);
        sb.push_back({1'b0, 16'hFFFF});
        exp_d[0]++;
        tick;
        st[0] = 1'b0;
        check("hold during busy", 32'(bcd[0]), 32'h4094);
        wait_done(0, "blank", 12);

        conv(1, "noblank fff", 16'h0FFF, {1'b0, 16'h4095}, 12);
        conv(1, "noblank 1", 16'd1, {1'b0, 16'h0001}, 12);

        conv(2, "w16 9999", 16'd9999, {1'b0, 16'h9999}, 16);
        conv(2, "w16 10000", 16'd10000, {1'b1, 16'h9999}, 16);
        conv(2, "w16 65535", 16'd65535, {1'b1, 16'h9999}, 16);
        conv(2, "w16 42", 16'd42, {1'b0, 16'h0042}, 16);

        // start while busy is ignored; start held through done gives back-to-back
        start_on(0, 16'd1234);
        sb.push_back({1'b0, 16'h1234});
        exp_d[0]++;
        tick;
        st[0] = 1'b0;
        repeat (4) tick;
        start_on(0, 16'd999);
        sb.push_back({1'b0, 16'h0999});
        exp_d[0]++;
        wait_done(0, "b2b first", 8);
        tick;
        st[0] = 1'b0;
        wait_done(0, "b2b second", 12);

        // reset mid-conversion abandons it without a done pulse
        start_on(0, 16'd1234);
        tick;
        st[0] = 1'b0;
        repeat (6) tick;
        rst_n = 1'b0;
        #1;
        check("abort bcd", 32'(bcd[0]), 32'd0);
        check("abort busy", 32'(busy[0]), 32'd0);
        check("abort done", 32'(done[0]), 32'd0);
        check("abort ovf", 32'(ovf[0]), 32'd0);
        repeat (20) tick;
        rst_n = 1'b1;
        tick;
        conv(0, "after reset", 16'd2048, {1'b0, 16'h2048}, 12);

        repeat (3) tick;
        for (int d = 0; d < 3; d++)
            check("done pulse count", dcnt[d], exp_d[d]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
